shift_normalizer: RTL and testbench



---
 rtl/shift_normalizer.sv | 107 ++++++++++
 tb/tb_shift_normalizer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_normalizer.sv
// Sequential left-normalizer: shifts one bit per clock until the leading
// significant bit (unsigned) or the bit below the sign (signed) reaches the top.
module shift_normalizer #(
  parameter int WIDTH = 32,
  parameter int CW    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] R,
  output logic [CW-1:0]    N,
  output logic             zero
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [CW-1:0]    n_q, n_d;
  logic             zero_q, zero_d;

  logic degen;
  logic term;

  // Signed -1 has no bit to expose below its sign, so it is degenerate like 0.
  assign degen = (a == '0) || (signed_mode && (a == '1));

  assign term = zero_q
             || (!mode_q && sh_q[WIDTH-1])
             || ( mode_q && (sh_q[WIDTH-1] != sh_q[WIDTH-2]))
             || (cnt_q == CW'(WIDTH-1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      r_q     <= '0;
      n_q     <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      r_q     <= r_d;
      n_q     <= n_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    r_d     = r_q;
    n_d     = n_q;
    zero_d  = zero_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          sh_d    = a;
          cnt_d   = '0;
          mode_d  = signed_mode;
          zero_d  = degen;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (term) begin
          r_d     = sh_q;
          n_d     = cnt_q;
          state_d = S_DONE;
        end else begin
          sh_d  = {sh_q[WIDTH-2:0], 1'b0};
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy = (state_q == S_SHIFT) || (state_q == S_DONE);
  assign done = (state_q == S_DONE);
  assign R    = r_q;
  assign N    = n_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_shift_normalizer.sv
// Directed bench for shift_normalizer: a latency/result model checked every
// cycle plus hand-computed expectations for each directed operation.
module tb_shift_normalizer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        signed_mode = 1'b0;
  logic [31:0] a = '0;
  logic        busy;
  logic        done;
  logic [31:0] R;
  logic [4:0]  N;
  logic        zero;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  shift_normalizer #(.WIDTH(32), .CW(5)) dut (
    .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode),
    .a(a), .busy(busy), .done(done), .R(R), .N(N), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_degen(input logic [31:0] v, input bit sm);
    return (v == 32'h0) || (sm && v == 32'hFFFF_FFFF);
  endfunction

  // Shift amount from first principles: leading zeros (unsigned) or
  // redundant sign bits (signed).
  function automatic int norm_count(input logic [31:0] v, input bit sm);
    int n;
    if (is_degen(v, sm)) return 0;
    n = 0;
    if (!sm) begin
      for (int i = 31; i >= 0; i--) begin
        if (v[i]) break;
        n++;
      end
    end else begin
      for (int i = 30; i >= 0; i--) begin
        if (v[i] != v[31]) break;
        n++;
      end
    end
    return (n > 31) ? 31 : n;
  endfunction

  // Model: remembers when done must appear and what it must report.
  bit          m_busy, m_done, m_zero;
  logic [31:0] m_R, m_pR;
  int          m_N, m_pN, m_rem;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 0; m_done = 0; m_zero = 0;
      m_R = '0; m_N = 0; m_rem = 0;
    end else if (!m_busy) begin
      if (start) begin
        m_pN   = norm_count(a, signed_mode);
        m_pR   = a << m_pN;
        m_zero = is_degen(a, signed_mode);
        m_busy = 1;
        m_rem  = m_pN + 1;
      end
    end else if (m_done) begin
      m_done = 0;
      m_busy = 0;
    end else begin
      m_rem--;
      if (m_rem == 0) begin
        m_done = 1;
        m_R = m_pR;
        m_N = m_pN;
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (chk_en && !reset) begin
      chk("m_busy", {31'b0, busy}, {31'b0, m_busy});
      chk("m_done", {31'b0, done}, {31'b0, m_done});
      chk("m_zero", {31'b0, zero}, {31'b0, m_zero});
      chk("m_R", R, m_R);
      chk("m_N", {27'b0, N}, m_N[31:0]);
    end
  end

  task automatic wait_done(output int e);
    e = 1;
    while (!done && e < 60) begin
      @(posedge clk); e++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string nm, input logic [31:0] av, input bit sm,
                        input logic [31:0] eR, input int eN, input bit eZ, input int eE);
    int e;
    @(negedge clk);
    a = av; signed_mode = sm; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(e);
    chk({nm, "_edge"}, e, eE);
    chk({nm, "_R"}, R, eR);
    chk({nm, "_N"}, {27'b0, N}, eN);
    chk({nm, "_zero"}, {31'b0, zero}, {31'b0, eZ});
    if (!eZ) begin
      chk({nm, "_inv_shl"}, R, av << N);
      if (sm) chk({nm, "_inv_sra"}, $signed(R) >>> N, av);
      else    chk({nm, "_inv_msb"}, {31'b0, R[31]}, 32'd1);
    end
  endtask

  initial begin
    int e, npulse;
    #2 reset = 1'b1;
    #20;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_R", R, 32'd0);
    chk("rst_N", {27'b0, N}, 32'd0);
    chk("rst_zero", {31'b0, zero}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;

    run_op("u_0xA",    32'h0000_000A, 0, 32'hA000_0000, 28, 0, 30);
    run_op("s_neg5",   32'hFFFF_FFFB, 1, 32'hB000_0000, 28, 0, 30);
    run_op("s_pos5",   32'h0000_0005, 1, 32'h5000_0000, 28, 0, 30);
    run_op("u_norm",   32'hAABB_CCDD, 0, 32'hAABB_CCDD, 0,  0, 2);
    run_op("u_zero",   32'h0000_0000, 0, 32'h0000_0000, 0,  1, 2);
    run_op("s_m1",     32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 0,  1, 2);
    run_op("u_ones",   32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 0,  0, 2);
    run_op("s_zero",   32'h0000_0000, 1, 32'h0000_0000, 0,  1, 2);
    run_op("s_top",    32'h4000_0000, 1, 32'h4000_0000, 0,  0, 2);
    run_op("s_min",    32'h8000_0000, 1, 32'h8000_0000, 0,  0, 2);

    // Handshake: a=1 runs to N=31; a start at edge 10 must be ignored.
    @(negedge clk);
    a = 32'h0000_0001; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); e = 1;
    @(negedge clk); start = 1'b0;
    while (e < 9) begin @(posedge clk); e++; @(negedge clk); end
    a = 32'h8000_0000; signed_mode = 1'b1; start = 1'b1;
    @(posedge clk); e++;
    @(negedge clk); start = 1'b0;
    chk("hs_busy_e10", {31'b0, busy}, 32'd1);
    while (!done && e < 60) begin @(posedge clk); e++; @(negedge clk); end
    chk("hs_edge", e, 33);
    chk("hs_R", R, 32'h8000_0000);
    chk("hs_N", {27'b0, N}, 32'd31);
    chk("hs_zero", {31'b0, zero}, 32'd0);

    // Start held through the DONE cycle is only accepted on the IDLE edge.
    a = 32'h0000_000A; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("hs_idle_gap", {31'b0, busy}, 32'd0);
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    wait_done(e);
    chk("hs2_edge", e, 30);
    chk("hs2_R", R, 32'hA000_0000);
    chk("hs2_N", {27'b0, N}, 32'd28);

    // Reset mid-SHIFT aborts without a done pulse.
    @(negedge clk);
    a = 32'h0000_0001; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    chk("pre_rst_busy", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("ar_busy", {31'b0, busy}, 32'd0);
    chk("ar_done", {31'b0, done}, 32'd0);
    chk("ar_R", R, 32'd0);
    chk("ar_N", {27'b0, N}, 32'd0);
    chk("ar_zero", {31'b0, zero}, 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    npulse = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) npulse++;
    end
    chk("ar_no_done", npulse, 0);
    chk("ar_R_hold", R, 32'd0);

    run_op("post_rst", 32'h0000_0005, 1, 32'h5000_0000, 28, 0, 30);

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
